std_dcache_flush_ctrl: RTL and testbench



---
 rtl/std_dcache_flush_ctrl_pkg.sv | 39 +++
 rtl/std_dcache_flush_ctrl_if.sv | 31 +++
 rtl/std_dcache_flush_ctrl_lzc.sv | 29 ++
 rtl/std_dcache_flush_ctrl.sv | 163 ++++++++++++++++
 tb/tb_std_dcache_flush_ctrl.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/std_dcache_flush_ctrl_pkg.sv
// Shared types for the L1 dcache flush sequencer.
// Cache geometry, SRAM line/byte-enable layout, FSM states, write-back bundle.
package std_dcache_flush_ctrl_pkg;

  localparam int unsigned DC_WAYS      = 8;
  localparam int unsigned DC_INDEX_W   = 12;
  localparam int unsigned DC_OFFSET_W  = 4;
  localparam int unsigned DC_TAG_W     = 44;
  localparam int unsigned DC_LINE_W    = 128;
  localparam int unsigned DC_WB_ADDR_W = 56;

  typedef struct packed {
    logic [DC_TAG_W-1:0]  tag;
    logic [DC_LINE_W-1:0] data;
    logic                 valid;
    logic                 dirty;
  } cache_line_t;

  typedef struct packed {
    logic [(DC_TAG_W+7)/8-1:0] tag;
    logic [DC_LINE_W/8-1:0]    data;
    logic [DC_WAYS-1:0]        vldrty;
  } cl_be_t;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    WB,
    INVAL,
    DONE
  } flush_state_e;

  typedef struct packed {
    logic [DC_WB_ADDR_W-1:0] addr;
    logic [DC_LINE_W-1:0]    data;
  } wb_req_t;

endpackage

// File: rtl/std_dcache_flush_ctrl_if.sv
// SRAM arbitration port plus line write-back channel of the flush sequencer.
// master: the sequencer (req/we/addr/be/wdata, wb_*), slave: SRAM side + WB sink.
interface std_dcache_flush_ctrl_if;
  import std_dcache_flush_ctrl_pkg::*;

  logic [DC_WAYS-1:0]       req_o;
  logic [DC_INDEX_W-1:0]    addr_o;
  logic                     gnt_i;
  logic                     we_o;
  cl_be_t                   be_o;
  cache_line_t              wdata_o;
  cache_line_t [DC_WAYS-1:0] rdata_i;

  logic                     wb_valid_o;
  logic                     wb_ready_i;
  logic [DC_WB_ADDR_W-1:0]  wb_addr_o;
  logic [DC_LINE_W-1:0]     wb_data_o;

  modport master (
    output req_o, addr_o, we_o, be_o, wdata_o,
    output wb_valid_o, wb_addr_o, wb_data_o,
    input  gnt_i, rdata_i, wb_ready_i
  );

  modport slave (
    input  req_o, addr_o, we_o, be_o, wdata_o,
    input  wb_valid_o, wb_addr_o, wb_data_o,
    output gnt_i, rdata_i, wb_ready_i
  );

endinterface

// File: rtl/std_dcache_flush_ctrl_lzc.sv
// Zero counter: index of first set bit from LSB (MODE=0) or MSB (MODE=1).
// in_i: vector, cnt_o: zero count, empty_o: no bit set.
module std_dcache_flush_ctrl_lzc #(
  parameter int unsigned WIDTH = 8,
  parameter bit          MODE  = 1'b0,
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             empty_o
);

  logic found;

  // Scanning from the chosen end, the loop position of the first hit
  // equals the zero count for both modes.
  always_comb begin
    cnt_o = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!found && in_i[MODE ? (WIDTH-1-i) : i]) begin
        cnt_o = CNT_W'(i);
        found = 1'b1;
      end
    end
    empty_o = !found;
  end

endmodule

// File: rtl/std_dcache_flush_ctrl.sv
// Walks every dcache set on flush: read ways, write back dirty lines, invalidate.
// clk_i/rst_i, flush_i/flush_ack_o/busy_o, bus: SRAM requester + write-back channel.
module std_dcache_flush_ctrl
  import std_dcache_flush_ctrl_pkg::*;
#(
  parameter int unsigned DCACHE_SET_ASSOC   = DC_WAYS,
  parameter int unsigned DCACHE_INDEX_WIDTH = DC_INDEX_W,
  parameter int unsigned DCACHE_BYTE_OFFSET = DC_OFFSET_W,
  parameter int unsigned DCACHE_TAG_WIDTH   = DC_TAG_W,
  parameter int unsigned DCACHE_LINE_WIDTH  = DC_LINE_W
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  output logic flush_ack_o,
  output logic busy_o,
  std_dcache_flush_ctrl_if.master bus
);

  localparam int unsigned SET_W = DCACHE_INDEX_WIDTH - DCACHE_BYTE_OFFSET;
  localparam int unsigned WAY_W = (DCACHE_SET_ASSOC > 1) ? $clog2(DCACHE_SET_ASSOC) : 1;

  flush_state_e state_q, state_d;

  logic [SET_W-1:0]            set_cnt_q, set_cnt_d;
  logic [DCACHE_SET_ASSOC-1:0] pend_q, pend_d;

  logic [DCACHE_SET_ASSOC-1:0][DCACHE_TAG_WIDTH-1:0]  tag_q;
  logic [DCACHE_SET_ASSOC-1:0][DCACHE_LINE_WIDTH-1:0] data_q;

  logic                          cap_en;
  logic [DCACHE_SET_ASSOC-1:0]   cap_mask;
  logic [WAY_W-1:0]              way;
  logic                          pend_empty;
  logic [DCACHE_SET_ASSOC-1:0]   way_oh;
  logic [DCACHE_SET_ASSOC-1:0]   pend_left;
  logic [DCACHE_INDEX_WIDTH-1:0] set_addr;
  wb_req_t                       wb_req;

  std_dcache_flush_ctrl_lzc #(
    .WIDTH (DCACHE_SET_ASSOC),
    .MODE  (1'b0)
  ) i_lzc (
    .in_i    (pend_q),
    .cnt_o   (way),
    .empty_o (pend_empty)
  );

  assign way_oh    = DCACHE_SET_ASSOC'(1) << way;
  assign pend_left = pend_q & ~way_oh;
  assign set_addr  = {set_cnt_q, {DCACHE_BYTE_OFFSET{1'b0}}};

  always_comb begin
    cap_mask = '0;
    for (int unsigned w = 0; w < DCACHE_SET_ASSOC; w++) begin
      cap_mask[w] = bus.rdata_i[w].valid & bus.rdata_i[w].dirty;
    end
  end

  always_comb begin
    state_d   = state_q;
    set_cnt_d = set_cnt_q;
    pend_d    = pend_q;
    cap_en    = 1'b0;

    bus.req_o      = '0;
    bus.addr_o     = '0;
    bus.we_o       = 1'b0;
    bus.be_o       = '0;
    bus.wdata_o    = '0;
    bus.wb_valid_o = 1'b0;
    wb_req         = '0;
    flush_ack_o    = 1'b0;
    busy_o         = (state_q != IDLE);

    unique case (state_q)
      IDLE: begin
        if (flush_i) begin
          set_cnt_d = '0;
          state_d   = READ;
        end
      end

      READ: begin
        bus.req_o  = '1;
        bus.addr_o = set_addr;
        if (bus.gnt_i) state_d = CAPTURE;
      end

      CAPTURE: begin
        cap_en  = 1'b1;
        pend_d  = cap_mask;
        state_d = (cap_mask == '0) ? INVAL : WB;
      end

      WB: begin
        if (pend_empty) begin
          state_d = INVAL;
        end else begin
          bus.wb_valid_o = 1'b1;
          wb_req.addr = DC_WB_ADDR_W'({tag_q[way], set_cnt_q,
                                       {DCACHE_BYTE_OFFSET{1'b0}}});
          wb_req.data = data_q[way];
          if (bus.wb_ready_i) begin
            pend_d = pend_left;
            if (pend_left == '0) state_d = INVAL;
          end
        end
      end

      INVAL: begin
        bus.req_o            = '1;
        bus.addr_o           = set_addr;
        bus.we_o             = 1'b1;
        bus.be_o.vldrty      = '1;
        if (bus.gnt_i) begin
          if (set_cnt_q == '1) begin
            state_d = DONE;
          end else begin
            set_cnt_d = set_cnt_q + 1'b1;
            state_d   = READ;
          end
        end
      end

      DONE: begin
        flush_ack_o = 1'b1;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.wb_addr_o = wb_req.addr;
  assign bus.wb_data_o = wb_req.data;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      set_cnt_q <= '0;
      pend_q    <= '0;
    end else begin
      state_q   <= state_d;
      set_cnt_q <= set_cnt_d;
      pend_q    <= pend_d;
    end
  end

  // Line snapshot taken in CAPTURE; the SRAM read port is free afterwards.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_q  <= '0;
      data_q <= '0;
    end else if (cap_en) begin
      for (int unsigned w = 0; w < DCACHE_SET_ASSOC; w++) begin
        tag_q[w]  <= bus.rdata_i[w].tag;
        data_q[w] <= bus.rdata_i[w].data;
      end
    end
  end

endmodule

// File: tb/tb_std_dcache_flush_ctrl.sv
// Directed bench for the dcache flush sequencer with an SRAM/WB responder.
// Expected cycle counts and write-back addresses are computed by hand.
module tb_std_dcache_flush_ctrl;
  import std_dcache_flush_ctrl_pkg::*;

  localparam int NSETS = 256;
  localparam int WAYS  = 8;
  localparam int CLEAN = 3*NSETS + 1;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic flush_ack;
  logic busy;

  std_dcache_flush_ctrl_if bus ();

  std_dcache_flush_ctrl dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .flush_ack_o (flush_ack),
    .busy_o      (busy),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  cache_line_t mem [NSETS][WAYS];
  wb_req_t     wbq [$];

  int ack_cnt, stab_err, wbstab_err;
  int rd_left, inv_left, wb_left;
  logic [11:0] stall_addr;
  bit rd_pend;
  int rd_set;
  bit inv5_seen;
  cl_be_t inv5_be;
  cache_line_t inv5_wd;

  bit p_wait, p_wbwait;
  logic [7:0] p_req;
  logic [11:0] p_addr;
  logic p_we;
  logic [55:0] p_wba;
  logic [127:0] p_wbd;

  // SRAM arbiter/array and write-back sink, evaluated mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      bus.gnt_i = 1'b1;
      bus.wb_ready_i = 1'b1;
      rd_pend = 1'b0;
      p_wait = 1'b0;
      p_wbwait = 1'b0;
    end else begin
      bus.gnt_i = 1'b1;
      if (bus.req_o != '0 && bus.addr_o == stall_addr) begin
        if (!bus.we_o && rd_left > 0) begin
          bus.gnt_i = 1'b0;
          rd_left--;
        end else if (bus.we_o && inv_left > 0) begin
          bus.gnt_i = 1'b0;
          inv_left--;
        end
      end
      if (p_wait && (bus.req_o !== p_req || bus.addr_o !== p_addr
                     || bus.we_o !== p_we))
        stab_err++;
      p_wait = (bus.req_o != '0) && !bus.gnt_i;
      p_req = bus.req_o;
      p_addr = bus.addr_o;
      p_we = bus.we_o;
      if (bus.req_o != '0 && bus.gnt_i) begin
        if (!bus.we_o) begin
          rd_pend = 1'b1;
          rd_set = int'(bus.addr_o[11:4]);
        end else begin
          for (int w = 0; w < WAYS; w++) begin
            if (bus.be_o.vldrty[w]) begin
              mem[bus.addr_o[11:4]][w].valid = 1'b0;
              mem[bus.addr_o[11:4]][w].dirty = 1'b0;
            end
          end
          if (bus.addr_o[11:4] == 8'd5) begin
            inv5_seen = 1'b1;
            inv5_be = bus.be_o;
            inv5_wd = bus.wdata_o;
          end
        end
      end

      bus.wb_ready_i = 1'b1;
      if (bus.wb_valid_o && wb_left > 0) begin
        bus.wb_ready_i = 1'b0;
        wb_left--;
      end
      if (p_wbwait && (!bus.wb_valid_o || bus.wb_addr_o !== p_wba
                       || bus.wb_data_o !== p_wbd))
        wbstab_err++;
      p_wbwait = bus.wb_valid_o && !bus.wb_ready_i;
      p_wba = bus.wb_addr_o;
      p_wbd = bus.wb_data_o;
      if (bus.wb_valid_o && bus.wb_ready_i)
        wbq.push_back('{addr: bus.wb_addr_o, data: bus.wb_data_o});
      if (flush_ack) ack_cnt++;
    end
  end

  // Read data appears the cycle after the granted read.
  always @(posedge clk) begin
    #1;
    if (rd_pend) begin
      for (int w = 0; w < WAYS; w++) bus.rdata_i[w] = mem[rd_set][w];
      rd_pend = 1'b0;
    end
  end

  task automatic clear_all();
    for (int s = 0; s < NSETS; s++)
      for (int w = 0; w < WAYS; w++) mem[s][w] = '0;
    wbq.delete();
    ack_cnt = 0;
    stab_err = 0;
    wbstab_err = 0;
    rd_left = 0;
    inv_left = 0;
    wb_left = 0;
    stall_addr = 12'hfff;
    inv5_seen = 1'b0;
  endtask

  task automatic run_flush(input int drop_at, output int cyc);
    cyc = -1;
    @(negedge clk);
    flush = 1'b1;
    for (int i = 1; i <= 3000; i++) begin
      @(posedge clk);
      #1;
      if (i == drop_at) flush = 1'b0;
      if (flush_ack) begin
        cyc = i;
        break;
      end
    end
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int cyc;
    clear_all();
    rst = 1'b1;
    flush = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, flush_ack, bus.wb_valid_o, bus.we_o} !== 4'b0) begin
      failures++;
      $display("FAIL reset_ctl: got %b want 0000",
               {busy, flush_ack, bus.wb_valid_o, bus.we_o});
    end
    checks++;
    if (bus.req_o !== 8'h0 || bus.addr_o !== 12'h0) begin
      failures++;
      $display("FAIL reset_req: got %h/%h want 0/0", bus.req_o, bus.addr_o);
    end
    @(negedge clk);
    #1 rst = 1'b0;
    #2;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_noclk: busy got %b want 0", busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({busy, bus.req_o, bus.addr_o, bus.we_o} !== {1'b1, 8'hff, 12'h0, 1'b0}) begin
      failures++;
      $display("FAIL first_read: got %b %h %h %b want 1 ff 000 0",
               busy, bus.req_o, bus.addr_o, bus.we_o);
    end
    cyc = -1;
    for (int i = 2; i <= 3000; i++) begin
      @(posedge clk);
      #1;
      if (flush_ack) begin
        cyc = i;
        break;
      end
    end
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cyc !== CLEAN) begin
      failures++;
      $display("FAIL clean_ack_cycle: got %0d want %0d", cyc, CLEAN);
    end
    checks++;
    if (wbq.size() !== 0) begin
      failures++;
      $display("FAIL clean_no_wb: got %0d want 0", wbq.size());
    end
    checks++;
    if (ack_cnt !== 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL clean_one_ack: got %0d busy %b want 1 busy 0", ack_cnt, busy);
    end
  endtask

  task automatic test_dirty_set();
    int cyc;
    logic [127:0] d2 = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
    logic [127:0] d6 = 128'hfeed_face_cafe_beef_8899_aabb_ccdd_eeff;
    logic [55:0] a2 = {44'habc, 8'd5, 4'h0};
    logic [55:0] a6 = {44'h123, 8'd5, 4'h0};
    clear_all();
    mem[5][2] = '{tag: 44'habc, data: d2, valid: 1'b1, dirty: 1'b1};
    mem[5][6] = '{tag: 44'h123, data: d6, valid: 1'b1, dirty: 1'b1};
    run_flush(0, cyc);
    checks++;
    if (cyc !== CLEAN + 2) begin
      failures++;
      $display("FAIL dirty_ack_cycle: got %0d want %0d", cyc, CLEAN + 2);
    end
    checks++;
    if (wbq.size() !== 2) begin
      failures++;
      $display("FAIL dirty_wb_count: got %0d want 2", wbq.size());
    end else begin
      checks++;
      if (wbq[0].addr !== a2 || wbq[0].data !== d2) begin
        failures++;
        $display("FAIL dirty_wb0: got %h want %h", wbq[0].addr, a2);
      end
      checks++;
      if (wbq[1].addr !== a6 || wbq[1].data !== d6) begin
        failures++;
        $display("FAIL dirty_wb1: got %h want %h", wbq[1].addr, a6);
      end
    end
    checks++;
    if (!inv5_seen || inv5_be !== cl_be_t'({{6+16{8'h0}}, 8'hff})) begin
      failures++;
      $display("FAIL inval_be: seen %b got %h want vldrty ff only",
               inv5_seen, inv5_be);
    end
    checks++;
    if (inv5_wd !== '0) begin
      failures++;
      $display("FAIL inval_wdata: got %h want 0", inv5_wd);
    end
    checks++;
    if ({mem[5][2].valid, mem[5][2].dirty, mem[5][6].valid, mem[5][6].dirty} !== 4'b0) begin
      failures++;
      $display("FAIL dirty_cleared: got %b want 0000",
               {mem[5][2].valid, mem[5][2].dirty, mem[5][6].valid, mem[5][6].dirty});
    end
  endtask

  task automatic test_clean_or_invalid();
    int cyc;
    clear_all();
    mem[9][1] = '{tag: 44'h111, data: 128'h1, valid: 1'b1, dirty: 1'b0};
    mem[9][3] = '{tag: 44'h333, data: 128'h3, valid: 1'b0, dirty: 1'b1};
    run_flush(0, cyc);
    checks++;
    if (cyc !== CLEAN) begin
      failures++;
      $display("FAIL mixed_ack_cycle: got %0d want %0d", cyc, CLEAN);
    end
    checks++;
    if (wbq.size() !== 0) begin
      failures++;
      $display("FAIL mixed_no_wb: got %0d want 0", wbq.size());
    end
    checks++;
    if (mem[9][1].valid !== 1'b0 || mem[9][3].dirty !== 1'b0) begin
      failures++;
      $display("FAIL mixed_inval: got v1=%b d3=%b want 0 0",
               mem[9][1].valid, mem[9][3].dirty);
    end
  endtask

  task automatic test_gnt_stall();
    int cyc;
    clear_all();
    stall_addr = {8'd7, 4'h0};
    rd_left = 7;
    inv_left = 4;
    run_flush(0, cyc);
    checks++;
    if (cyc !== CLEAN + 11) begin
      failures++;
      $display("FAIL gnt_ack_cycle: got %0d want %0d", cyc, CLEAN + 11);
    end
    checks++;
    if (rd_left !== 0 || inv_left !== 0) begin
      failures++;
      $display("FAIL gnt_stall_used: got %0d/%0d want 0/0", rd_left, inv_left);
    end
    checks++;
    if (stab_err !== 0) begin
      failures++;
      $display("FAIL gnt_req_stable: got %0d changes want 0", stab_err);
    end
  endtask

  task automatic test_wb_stall_drop();
    int cyc;
    logic [55:0] a0 = {44'h77, 8'd20, 4'h0};
    logic [55:0] a3 = {44'h88, 8'd20, 4'h0};
    clear_all();
    mem[20][0] = '{tag: 44'h77, data: 128'haaaa, valid: 1'b1, dirty: 1'b1};
    mem[20][3] = '{tag: 44'h88, data: 128'hbbbb, valid: 1'b1, dirty: 1'b1};
    wb_left = 10;
    run_flush(30, cyc);
    checks++;
    if (cyc !== CLEAN + 12) begin
      failures++;
      $display("FAIL wbstall_ack_cycle: got %0d want %0d", cyc, CLEAN + 12);
    end
    checks++;
    if (wbstab_err !== 0) begin
      failures++;
      $display("FAIL wb_stable: got %0d changes want 0", wbstab_err);
    end
    checks++;
    if (wbq.size() !== 2) begin
      failures++;
      $display("FAIL wbstall_count: got %0d want 2", wbq.size());
    end else begin
      checks++;
      if (wbq[0].addr !== a0 || wbq[1].addr !== a3 || wbq[0].data !== 128'haaaa) begin
        failures++;
        $display("FAIL wbstall_order: got %h,%h want %h,%h",
                 wbq[0].addr, wbq[1].addr, a0, a3);
      end
    end
    checks++;
    if (ack_cnt !== 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL drop_one_ack: got %0d busy %b want 1 busy 0", ack_cnt, busy);
    end
  endtask

  task automatic test_reset_mid_wb();
    int cyc;
    bit hit;
    logic [55:0] a4 = {44'h5a5, 8'd100, 4'h0};
    clear_all();
    mem[100][4] = '{tag: 44'h5a5, data: 128'hc0de, valid: 1'b1, dirty: 1'b1};
    wb_left = 1000;
    hit = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (bus.wb_valid_o) begin
        hit = 1'b1;
        break;
      end
    end
    checks++;
    if (!hit || bus.wb_addr_o !== a4) begin
      failures++;
      $display("FAIL mid_wb_reach: hit %b got %h want %h", hit, bus.wb_addr_o, a4);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, flush_ack, bus.wb_valid_o, bus.we_o, bus.req_o, bus.addr_o} !== '0
        || bus.wb_addr_o !== 56'h0) begin
      failures++;
      $display("FAIL mid_reset_outs: busy %b wbv %b req %h wba %h want all 0",
               busy, bus.wb_valid_o, bus.req_o, bus.wb_addr_o);
    end
    wb_left = 0;
    flush = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    checks++;
    if (ack_cnt !== 0) begin
      failures++;
      $display("FAIL mid_reset_no_ack: got %0d want 0", ack_cnt);
    end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({busy, bus.req_o, bus.addr_o, bus.we_o} !== {1'b1, 8'hff, 12'h0, 1'b0}) begin
      failures++;
      $display("FAIL restart_set0: got %b %h %h %b want 1 ff 000 0",
               busy, bus.req_o, bus.addr_o, bus.we_o);
    end
    cyc = -1;
    for (int i = 2; i <= 3000; i++) begin
      @(posedge clk);
      #1;
      if (flush_ack) begin
        cyc = i;
        break;
      end
    end
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (cyc !== CLEAN + 1) begin
      failures++;
      $display("FAIL restart_ack_cycle: got %0d want %0d", cyc, CLEAN + 1);
    end
    checks++;
    if (wbq.size() !== 1) begin
      failures++;
      $display("FAIL restart_wb_count: got %0d want 1", wbq.size());
    end else begin
      checks++;
      if (wbq[0].addr !== a4) begin
        failures++;
        $display("FAIL restart_wb_addr: got %h want %h", wbq[0].addr, a4);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    test_reset();
    test_dirty_set();
    test_clean_or_invalid();
    test_gnt_stall();
    test_wb_stall_drop();
    test_reset_mid_wb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
